// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory / write-back stage.
// Holds the FSM state type, funct3 size encodings, byte-enable constants and access helpers.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RSP  = 2'b10,
    WB   = 2'b11
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic        mem_we;
    logic        mem2rf;
    logic [2:0]  funct3;
  } ex_op_t;

  // Stores share the load size encodings, so one decode serves both directions.
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                             input logic [1:0] offset);
    case (funct3)
      F3_LB, F3_LBU: byte_enable = BE_BYTE0 << offset;
      F3_LH, F3_LHU: byte_enable = offset[1] ? BE_HALF_HI : BE_HALF_LO;
      default:       byte_enable = BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] data);
    case (funct3)
      F3_LB, F3_LBU: store_lanes = {4{data[7:0]}};
      F3_LH, F3_LHU: store_lanes = {2{data[15:0]}};
      default:       store_lanes = data;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    case (funct3)
      F3_LB, F3_LBU: is_misaligned = 1'b0;
      F3_LH, F3_LHU: is_misaligned = offset[0];
      default:       is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends load data from the returned word according to size and offset.
// With WB_SUBWORD_EN undefined every load is a plain word and the data passes through.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

`ifdef WB_SUBWORD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{addr_i, funct3_i};
  assign data_o     = rdata_i;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// Memory / write-back stage: one data-memory access per op, then a register-file write.
// Byte/halfword accesses are enabled by defining WB_SUBWORD_EN; otherwise all accesses are words.
module mem_wb_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rf_waddr_i,
  input  logic        rf_we_i,
  input  logic        mem_we_i,
  input  logic        mem2rf_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        rf_we_o,
  output logic [31:0] rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        misalign_o
);

  wb_state_e   state_q, state_d;
  ex_op_t      hold_q, hold_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        misalign_q, misalign_d;

  logic        is_mem_op;
  logic        req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] load_data;
  logic        unused_hold;

`ifdef WB_SUBWORD_EN
  assign req_be         = byte_enable(funct3_i, alu_result_i[1:0]);
  assign req_wdata      = store_lanes(funct3_i, store_data_i);
  assign req_misaligned = is_misaligned(funct3_i, alu_result_i[1:0]);
`else
  assign req_be         = BE_WORD;
  assign req_wdata      = store_data_i;
  assign req_misaligned = (alu_result_i[1:0] != 2'b00);
`endif

  assign is_mem_op   = mem_we_i | mem2rf_i;
  assign unused_hold = ^{hold_q.alu_result[31:2], hold_q.store_data, hold_q.mem2rf};

  load_align u_load_align (
    .rdata_i  (dmem_rdata_i),
    .addr_i   (hold_q.alu_result[1:0]),
    .funct3_i (hold_q.funct3),
    .data_o   (load_data)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    misalign_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          hold_d.alu_result = alu_result_i;
          hold_d.store_data = store_data_i;
          hold_d.rf_waddr   = rf_waddr_i;
          hold_d.rf_we      = rf_we_i;
          hold_d.mem_we     = mem_we_i;
          hold_d.mem2rf     = mem2rf_i;
          hold_d.funct3     = funct3_i;
          if (!is_mem_op) begin
            state_d    = WB;
            rf_we_d    = rf_we_i && (rf_waddr_i != 5'd0);
            rf_waddr_d = rf_waddr_i;
            rf_wdata_d = alu_result_i;
          end else if (req_misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d      = REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_we_i;
            dmem_addr_d  = {alu_result_i[31:2], 2'b00};
            dmem_be_d    = req_be;
            dmem_wdata_d = req_wdata;
          end
        end
      end
      // A response arriving alongside the grant belongs to nothing; only the grant counts.
      REQ: begin
        if (dmem_gnt_i) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          state_d    = hold_q.mem_we ? IDLE : RSP;
        end
      end
      RSP: begin
        if (dmem_rvalid_i) begin
          state_d    = WB;
          rf_we_d    = hold_q.rf_we && (hold_q.rf_waddr != 5'd0);
          rf_waddr_d = hold_q.rf_waddr;
          rf_wdata_d = load_data;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_be_q    <= BE_NONE;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      misalign_q   <= misalign_d;
    end
  end

  assign ex_ready_o   = (state_q == IDLE);
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign dmem_be_o    = dmem_be_q;
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = {27'd0, rf_waddr_q};
  assign rf_wdata_o   = rf_wdata_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: a table of complete transactions plus hand-written
// sequences for grant/response overlap and reset in flight. Sub-word vectors follow WB_SUBWORD_EN.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic [4:0]  rf_waddr_i;
  logic        rf_we_i;
  logic        mem_we_i;
  logic        mem2rf_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        rf_we_o;
  logic [31:0] rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        misalign_o;

  int total;
  int bad;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rfwe;
    logic        mwe;
    logic        m2r;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic        exp_rfwe;
    logic [31:0] exp_rfwdata;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  mem_wb_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .alu_result_i  (alu_result_i),
    .store_data_i  (store_data_i),
    .rf_waddr_i    (rf_waddr_i),
    .rf_we_i       (rf_we_i),
    .mem_we_i      (mem_we_i),
    .mem2rf_i      (mem2rf_i),
    .funct3_i      (funct3_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] sdata,
                              input logic [4:0] rd, input logic rfwe,
                              input logic mwe, input logic m2r, input logic [2:0] f3,
                              input logic [31:0] rdata, input logic exp_req,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic exp_mis,
                              input logic exp_rfwe, input logic [31:0] exp_rfwdata);
    vec_t v;
    v.alu = alu; v.sdata = sdata; v.rd = rd; v.rfwe = rfwe;
    v.mwe = mwe; v.m2r = m2r; v.f3 = f3; v.rdata = rdata;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_mis = exp_mis;
    v.exp_rfwe = exp_rfwe; v.exp_rfwdata = exp_rfwdata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (case %0d): got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rd,
                       input logic rfwe, input logic mwe, input logic m2r, input logic [2:0] f3);
    ex_valid_i   = 1'b1;
    alu_result_i = alu;
    store_data_i = sdata;
    rf_waddr_i   = rd;
    rf_we_i      = rfwe;
    mem_we_i     = mwe;
    mem2rf_i     = m2r;
    funct3_i     = f3;
  endtask

  // Runs one whole transaction (called at a negedge, returns at a negedge, stage idle).
  task automatic applyStimulus(input int idx, input vec_t v);
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic        stable;
    int          extra_we;
    extra_we = 0;
    stable   = 1'b1;
    offer(v.alu, v.sdata, v.rd, v.rfwe, v.mwe, v.m2r, v.f3);
    checkOutput("ready_offer", idx, ex_ready_o, 1);
    cycle();
    ex_valid_i = 1'b0;
    checkOutput("req", idx, dmem_req_o, v.exp_req);
    checkOutput("misalign", idx, misalign_o, v.exp_mis);
    if (!v.exp_req) begin
      if (!v.mwe && !v.m2r) checkOutput("ready_wb", idx, ex_ready_o, 0);
    end else begin
      checkOutput("dmem_we", idx, dmem_we_o, v.mwe);
      checkOutput("dmem_addr", idx, dmem_addr_o, v.exp_addr);
      checkOutput("dmem_be", idx, dmem_be_o, v.exp_be);
      if (v.mwe) checkOutput("dmem_wdata", idx, dmem_wdata_o, v.exp_wdata);
      a_we = dmem_we_o; a_addr = dmem_addr_o; a_wdata = dmem_wdata_o; a_be = dmem_be_o;
      extra_we += rf_we_o;
      for (int k = 0; k < 2; k++) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hBAD0_0000 | k;
        cycle();
        dmem_rvalid_i = 1'b0;
        if (dmem_req_o !== 1'b1 || dmem_we_o !== a_we || dmem_addr_o !== a_addr ||
            dmem_wdata_o !== a_wdata || dmem_be_o !== a_be) stable = 1'b0;
        extra_we += rf_we_o;
      end
      checkOutput("req_stable", idx, stable, 1);
      dmem_gnt_i = 1'b1;
      cycle();
      dmem_gnt_i = 1'b0;
      checkOutput("req_drop", idx, dmem_req_o, 0);
      if (!v.mwe) begin
        extra_we += rf_we_o;
        repeat (2) begin
          cycle();
          extra_we += rf_we_o;
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = v.rdata;
        cycle();
        dmem_rvalid_i = 1'b0;
      end
    end
    checkOutput("rf_we", idx, rf_we_o, v.exp_rfwe);
    if (v.exp_rfwe) begin
      checkOutput("rf_waddr", idx, rf_waddr_o, {27'd0, v.rd});
      checkOutput("rf_wdata", idx, rf_wdata_o, v.exp_rfwdata);
    end
    cycle();
    checkOutput("rf_we_clear", idx, rf_we_o, 0);
    checkOutput("ready_after", idx, ex_ready_o, 1);
    checkOutput("misalign_clear", idx, misalign_o, 0);
    checkOutput("req_idle", idx, dmem_req_o, 0);
    checkOutput("extra_rf_we", idx, extra_we, 0);
  endtask

  initial begin
    int cnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ex_valid_i = 1'b0; alu_result_i = '0; store_data_i = '0; rf_waddr_i = '0;
    rf_we_i = 1'b0; mem_we_i = 1'b0; mem2rf_i = 1'b0; funct3_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

    //                alu            sdata          rd  we mwe m2r f3      rdata          req addr          be       wdata          mis rfwe rfwdata
    vecs[0]  = mk(32'h0000_1234, 32'h0,          5,  1, 0, 0, 3'b000, 32'h0,         0, 32'h0,       4'h0,    32'h0,         0, 1, 32'h0000_1234);
    vecs[1]  = mk(32'hFFFF_0001, 32'h0,          0,  1, 0, 0, 3'b000, 32'h0,         0, 32'h0,       4'h0,    32'h0,         0, 0, 32'h0);
    vecs[2]  = mk(32'h0000_0077, 32'h0,          9,  0, 0, 0, 3'b000, 32'h0,         0, 32'h0,       4'h0,    32'h0,         0, 0, 32'h0);
    vecs[3]  = mk(32'h0000_0100, 32'h0,          7,  1, 0, 1, 3'b010, 32'hDEADBEEF,  1, 32'h100,     4'b1111, 32'h0,         0, 1, 32'hDEADBEEF);
    vecs[4]  = mk(32'h0000_0104, 32'h0,          0,  1, 0, 1, 3'b010, 32'h5555AAAA,  1, 32'h104,     4'b1111, 32'h0,         0, 0, 32'h0);
    vecs[5]  = mk(32'h0000_0204, 32'hCAFEF00D,   6,  0, 1, 0, 3'b010, 32'h0,         1, 32'h204,     4'b1111, 32'hCAFEF00D,  0, 0, 32'h0);
    vecs[6]  = mk(32'h0000_0102, 32'h0,          4,  1, 0, 1, 3'b010, 32'h0,         0, 32'h0,       4'h0,    32'h0,         1, 0, 32'h0);
    vecs[7]  = mk(32'h0000_0201, 32'h1111_2222,  0,  0, 1, 0, 3'b010, 32'h0,         0, 32'h0,       4'h0,    32'h0,         1, 0, 32'h0);
    vecs[14] = mk(32'h0000_0101, 32'h0,          8,  1, 0, 1, 3'b001, 32'h0,         0, 32'h0,       4'h0,    32'h0,         1, 0, 32'h0);
`ifdef WB_SUBWORD_EN
    vecs[8]  = mk(32'h0000_0103, 32'h0,         10,  1, 0, 1, 3'b000, 32'h80FFFFFF,  1, 32'h100,     4'b1000, 32'h0,         0, 1, 32'hFFFFFF80);
    vecs[9]  = mk(32'h0000_0103, 32'h0,         11,  1, 0, 1, 3'b100, 32'h80FFFFFF,  1, 32'h100,     4'b1000, 32'h0,         0, 1, 32'h00000080);
    vecs[10] = mk(32'h0000_0102, 32'h0000ABCD,   0,  0, 1, 0, 3'b001, 32'h0,         1, 32'h100,     4'b1100, 32'hABCDABCD,  0, 0, 32'h0);
    vecs[11] = mk(32'h0000_0102, 32'h0,         12,  1, 0, 1, 3'b001, 32'h80011234,  1, 32'h100,     4'b1100, 32'h0,         0, 1, 32'hFFFF8001);
    vecs[12] = mk(32'h0000_0100, 32'h0,         13,  1, 0, 1, 3'b101, 32'h12349ABC,  1, 32'h100,     4'b0011, 32'h0,         0, 1, 32'h00009ABC);
    vecs[13] = mk(32'h0000_0301, 32'h12345678,   0,  0, 1, 0, 3'b000, 32'h0,         1, 32'h300,     4'b0010, 32'h78787878,  0, 0, 32'h0);
    vecs[15] = mk(32'h0000_0100, 32'h0,         14,  1, 0, 1, 3'b000, 32'h1122337F,  1, 32'h100,     4'b0001, 32'h0,         0, 1, 32'h0000007F);
    vecs[16] = mk(32'h0000_0102, 32'h0,         15,  1, 0, 1, 3'b000, 32'h00F50000,  1, 32'h100,     4'b0100, 32'h0,         0, 1, 32'hFFFFFFF5);
`else
    vecs[8]  = mk(32'h0000_0103, 32'h0,         10,  1, 0, 1, 3'b000, 32'h80FFFFFF,  0, 32'h0,       4'h0,    32'h0,         1, 0, 32'h0);
    vecs[9]  = mk(32'h0000_0103, 32'h0,         11,  1, 0, 1, 3'b100, 32'h80FFFFFF,  0, 32'h0,       4'h0,    32'h0,         1, 0, 32'h0);
    vecs[10] = mk(32'h0000_0102, 32'h0000ABCD,   0,  0, 1, 0, 3'b001, 32'h0,         0, 32'h0,       4'h0,    32'h0,         1, 0, 32'h0);
    vecs[11] = mk(32'h0000_0102, 32'h0,         12,  1, 0, 1, 3'b001, 32'h80011234,  0, 32'h0,       4'h0,    32'h0,         1, 0, 32'h0);
    vecs[12] = mk(32'h0000_0100, 32'h0,         13,  1, 0, 1, 3'b101, 32'h12349ABC,  1, 32'h100,     4'b1111, 32'h0,         0, 1, 32'h12349ABC);
    vecs[13] = mk(32'h0000_0301, 32'h12345678,   0,  0, 1, 0, 3'b000, 32'h0,         0, 32'h0,       4'h0,    32'h0,         1, 0, 32'h0);
    vecs[15] = mk(32'h0000_0100, 32'h0,         14,  1, 0, 1, 3'b000, 32'h1122337F,  1, 32'h100,     4'b1111, 32'h0,         0, 1, 32'h1122337F);
    vecs[16] = mk(32'h0000_0102, 32'h0,         15,  1, 0, 1, 3'b000, 32'h00F50000,  0, 32'h0,       4'h0,    32'h0,         1, 0, 32'h0);
`endif

    // Reset values, then the ready flag once released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", -1, dmem_req_o, 0);
    checkOutput("rst_we", -1, dmem_we_o, 0);
    checkOutput("rst_be", -1, dmem_be_o, 0);
    checkOutput("rst_addr", -1, dmem_addr_o, 0);
    checkOutput("rst_wdata", -1, dmem_wdata_o, 0);
    checkOutput("rst_rf_we", -1, rf_we_o, 0);
    checkOutput("rst_rf_waddr", -1, rf_waddr_o, 0);
    checkOutput("rst_rf_wdata", -1, rf_wdata_o, 0);
    checkOutput("rst_misalign", -1, misalign_o, 0);
    rst_n = 1'b1;
    cycle();
    checkOutput("rst_ready", -1, ex_ready_o, 1);

    for (int i = 0; i < NVEC; i++) applyStimulus(i, vecs[i]);

    // Grant and response in the same cycle: the response is not the load data.
    offer(32'h40, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 3'b010);
    cycle();
    ex_valid_i    = 1'b0;
    dmem_gnt_i    = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1111_1111;
    cycle();
    dmem_gnt_i    = 1'b0;
    checkOutput("same_cycle_rf_we", 100, rf_we_o, 0);
    checkOutput("same_cycle_ready", 100, ex_ready_o, 0);
    dmem_rdata_i  = 32'h2222_2222;
    cycle();
    dmem_rvalid_i = 1'b0;
    checkOutput("same_cycle_late_we", 100, rf_we_o, 1);
    checkOutput("same_cycle_late_data", 100, rf_wdata_o, 32'h2222_2222);
    checkOutput("same_cycle_late_addr", 100, rf_waddr_o, 32'd3);
    cycle();

    // Reset while the request is outstanding: request drops at once, later grant ignored.
    offer(32'h80, 32'h5A5A_5A5A, 5'd0, 1'b0, 1'b1, 1'b0, 3'b010);
    cycle();
    ex_valid_i = 1'b0;
    checkOutput("rreq_req_before", 101, dmem_req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rreq_req", 101, dmem_req_o, 0);
    checkOutput("rreq_we", 101, dmem_we_o, 0);
    checkOutput("rreq_be", 101, dmem_be_o, 0);
    checkOutput("rreq_addr", 101, dmem_addr_o, 0);
    checkOutput("rreq_ready", 101, ex_ready_o, 1);
    @(negedge clk);
    rst_n      = 1'b1;
    dmem_gnt_i = 1'b1;
    cycle();
    dmem_gnt_i = 1'b0;
    checkOutput("rreq_after_req", 101, dmem_req_o, 0);
    checkOutput("rreq_after_ready", 101, ex_ready_o, 1);

    // Reset while waiting for load data: the stale response must not be written back.
    offer(32'h100, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 3'b010);
    cycle();
    ex_valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    cycle();
    dmem_gnt_i = 1'b0;
    checkOutput("rrsp_in_rsp", 102, ex_ready_o, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rrsp_req", 102, dmem_req_o, 0);
    checkOutput("rrsp_rf_we", 102, rf_we_o, 0);
    checkOutput("rrsp_ready", 102, ex_ready_o, 1);
    @(negedge clk);
    rst_n         = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    cycle();
    dmem_rvalid_i = 1'b0;
    cnt = rf_we_o;
    repeat (3) begin
      cycle();
      cnt += rf_we_o;
    end
    checkOutput("rrsp_no_write", 102, cnt, 0);
    checkOutput("rrsp_wdata", 102, rf_wdata_o, 0);
    checkOutput("rrsp_idle", 102, ex_ready_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; one clock; reset is asynchronous and active-low (rst_n  in  1).
REQ-002 SHALL have ex_valid_i in 1 (op offered); ex_ready_o out 1 (op accepted when both high).
REQ-003 SHALL have alu_result_i in 32 (result/address), store_data_i in 32, rf_waddr_i in 5, rf_we_i in 1, mem_we_i in 1, mem2rf_i in 1, funct3_i in 3 (access size).
REQ-004 SHALL have dmem_req_o out 1, dmem_we_o out 1, dmem_addr_o out 32, dmem_wdata_o out 32, dmem_be_o out 4, dmem_gnt_i in 1, dmem_rvalid_i in 1, dmem_rdata_i in 32.
REQ-005 SHALL have rf_we_o out 1, rf_waddr_o out 32 (bits [31:5] zero), rf_wdata_o out 32 (register-file write port driving decode), misalign_o out 1.

Function
REQ-006 SHALL implement FSM IDLE, REQ, RSP, WB; ex_ready_o = 1 only in IDLE.
REQ-007 SHALL capture all ex_* fields into a holding register on accept.
REQ-008 SHALL, for non-memory op (mem_we_i=0, mem2rf_i=0) accepted at cycle N: IDLE->WB, rf_we_o pulse at N+1 with rf_wdata_o = alu_result_i, then WB->IDLE.
REQ-009 SHALL, for load/store accepted at N: enter REQ, assert dmem_req_o from N+1, hold dmem_we_o/addr/wdata/be stable until dmem_gnt_i=1.
REQ-010 SHALL drive dmem_addr_o = {addr[31:2],2'b00}; dmem_be_o from size and addr[1:0]; dmem_wdata_o = store data replicated to the selected lanes.
REQ-011 SHALL, on grant of a store, return to IDLE with no rf write; on grant of a load, enter RSP.
REQ-012 SHALL, in RSP, on dmem_rvalid_i=1 capture aligned/extended load data and enter WB; rf_we_o pulses the following cycle.
REQ-013 SHALL treat gnt and rvalid in the same cycle as grant only; rvalid counts from the cycle after grant.
REQ-014 SHALL ignore dmem_rvalid_i outside RSP and dmem_gnt_i outside REQ.
REQ-015 SHALL suppress rf_we_o when the destination is x0 (rf_waddr=0) or rf_we_i was 0.
REQ-016 SHALL, on misaligned access (halfword addr[0]=1, word addr[1:0]!=0), issue no memory request, no rf write, pulse misalign_o for one cycle, stay in IDLE.
REQ-017 SHALL hold rf_we_o=0 in every state except WB; rf_waddr_o/rf_wdata_o hold last value otherwise.

Reset
REQ-018 SHALL on rst_n=0 asynchronously force IDLE, ex_ready_o=1 after release, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, misalign_o=0.
REQ-019 SHALL abandon any in-flight op on reset; a response arriving after reset is discarded (REQ-014).

Configuration
REQ-020 SHALL with WB_SUBWORD_EN defined support funct3 LB/LH/LW/LBU/LHU and SB/SH/SW with sign/zero extension and lane selection.
REQ-021 SHALL without WB_SUBWORD_EN treat every access as word (dmem_be_o=4'b1111), ignore funct3_i, and apply only word misalignment checks.

Structure
REQ-022 SHALL place FSM state enum, funct3 size encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101) and byte-enable constants in shared package riscv_pkg.
REQ-023 SHALL implement extraction/extension in combinational sub-module load_align (inputs rdata, addr[1:0], funct3; output 32-bit data).

Verification
REQ-024 ALU op rf_waddr=5, alu=0x1234 accepted cycle N -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234 at N+1, ex_ready_o=1 at N+2.
REQ-025 LW addr 0x100, rd=7, gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF -> dmem_addr_o=0x100, be=1111 stable until gnt; rf x7 <= 0xDEADBEEF one cycle after rvalid.
REQ-026 (WB_SUBWORD_EN) LB addr 0x103, rdata 0x80FFFFFF -> rf_wdata_o=0xFFFFFF80; LBU same -> 0x00000080; SH addr 0x102 data 0xABCD -> be=1100, wdata=0xABCDABCD.
REQ-027 LW addr 0x102 -> misalign_o one-cycle pulse, dmem_req_o never asserted, rf_we_o stays 0.
REQ-028 LW rd=0 -> memory transaction completes, rf_we_o stays 0; ALU op rd=0 -> rf_we_o stays 0.
REQ-029 Reset asserted in RSP, rvalid arrives after release -> dmem_req_o=0 immediately, state IDLE, no rf_we_o pulse.
